pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have derived parameter SHW, default log2(WIDTH), meaning shift-amount width and pipeline depth.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand.
REQ-008 SHALL have port b  input  SHW  shift/rotate amount, 0..WIDTH-1.
REQ-009 SHALL have port aluc  input  3  mode select.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port c  output  WIDTH  result.
REQ-013 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-014 SHALL have port zero  output  1  high when c is all zeros.

Function
REQ-015 SHALL decode aluc as follows: 000 = arithmetic right (SRA); 010 = logical right (SRL); 001 and 011 = logical left (SLL); 100 and 110 = rotate right (ROR); 101 and 111 = rotate left (ROL).
REQ-016 SHALL implement SHW register stages; stage k shifts or rotates by 2^k when b[k]=1 and passes data through unchanged otherwise.
REQ-017 SHALL carry a valid bit, the mode and the running carry alongside the data in each stage.
REQ-018 SHALL define advance = !out_valid || out_ready and drive in_ready = advance combinationally.
REQ-019 SHALL move all stages forward one position on a cycle when advance=1; stage 0 loads in_valid&&in_ready and its operands.
REQ-020 SHALL hold every stage register unchanged when advance=0, so c, carry, zero and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-021 SHALL present the result of a beat accepted on cycle t with out_valid=1 in cycle t+SHW when no stall occurs; each stall cycle adds exactly one cycle.
REQ-022 SHALL sustain one result per cycle when out_ready=1 continuously; bubbles propagate and are not compressed.
REQ-023 SHALL fill SRA vacated bits with a[WIDTH-1], and SRL/SLL vacated bits with 0.
REQ-024 SHALL set carry, for b=n>0: SLL = a[WIDTH-n]; SRL/SRA = a[n-1]; ROL = c[0]; ROR = c[WIDTH-1]. For b=0, carry=0 in all modes.
REQ-025 SHALL compute zero from the registered final-stage c.
REQ-026 SHALL leave c, carry and zero don't-care while out_valid=0; the bench checks them only when out_valid=1.
REQ-027 SHALL never drop or duplicate a beat; the output order equals the acceptance order.

Reset
REQ-028 SHALL, while rst=1 at a rising clock edge, clear all stage valid bits, clear c to 0, clear carry to 0 and set zero to 1.
REQ-029 SHALL discard in-flight beats when reset is asserted mid-operation; no beat accepted before reset appears at the output afterwards.
REQ-030 SHALL drive out_valid=0 and in_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL ignore in_valid in any cycle where rst=1.

Verification (WIDTH=32 unless stated; latency 5)
REQ-032 SHALL verify: SRA a=0x80000000 b=4 -> c=0xF8000000, carry=0, zero=0, exactly 5 cycles after acceptance.
REQ-033 SHALL verify: SLL a=0x00000003 b=31 -> c=0x80000000, carry=1; SRL a=0xF0000000 b=28 -> c=0x0000000F, carry=0; SRL a=0x1 b=1 -> c=0, carry=1, zero=1.
REQ-034 SHALL verify: ROR a=0x00000001 b=1 -> c=0x80000000, carry=1; ROL a=0x80000001 b=4 -> c=0x00000018, carry=0; any mode with b=0 -> c=a, carry=0.
REQ-035 SHALL verify: 8 back-to-back beats with out_ready held 0 for 3 cycles mid-stream -> all 8 results in order, outputs stable while stalled, in_ready=0 during the stall.
REQ-036 SHALL verify: rst pulsed for 1 cycle with 3 beats in flight -> none emerge, out_valid=0 and in_ready=1 the next cycle, and the next accepted beat appears 5 cycles later.
REQ-037 SHALL verify: WIDTH=8 build with SRA a=0x90 b=3 -> c=0xF2, carry=0, latency 3 cycles.

Source files
------------

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready flow control.
// Stage k applies a 2^k shift/rotate when b[k] is set; carry tracks the last bit moved out.
`timescale 1ns/1ps
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero
);

  typedef struct packed {
    logic             valid;
    logic [2:0]       mode;
    logic [SHW-1:0]   amt;
    logic             cy;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st_q [SHW];
  stage_t st_d [SHW];
  stage_t in_stage;
  logic   advance;

  // Left-type moves lose bit WIDTH-sh last; right-type moves lose bit sh-1 last.
  function automatic stage_t step(input stage_t s_in, input int k);
    stage_t           r;
    int               sh;
    logic [SHW-1:0]   sel;
    logic [WIDTH-1:0] tl;
    logic [WIDTH-1:0] tr;
    r   = s_in;
    sh  = 1 << k;
    sel = SHW'(1) << k;
    tl  = s_in.data >> (WIDTH - sh);
    tr  = s_in.data << (WIDTH - sh);
    if ((s_in.amt & sel) != '0) begin
      case (s_in.mode)
        3'b000: begin
          r.data = $signed(s_in.data) >>> sh;
          r.cy   = tr[WIDTH-1];
        end
        3'b010: begin
          r.data = s_in.data >> sh;
          r.cy   = tr[WIDTH-1];
        end
        3'b001, 3'b011: begin
          r.data = s_in.data << sh;
          r.cy   = tl[0];
        end
        3'b100, 3'b110: begin
          r.data = (s_in.data >> sh) | (s_in.data << (WIDTH - sh));
          r.cy   = tr[WIDTH-1];
        end
        3'b101, 3'b111: begin
          r.data = (s_in.data << sh) | (s_in.data >> (WIDTH - sh));
          r.cy   = tl[0];
        end
        default: r = s_in;
      endcase
    end else begin
      r = s_in;
    end
    return r;
  endfunction

  assign advance   = !st_q[SHW-1].valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = st_q[SHW-1].valid;
  assign c         = st_q[SHW-1].data;
  assign carry     = st_q[SHW-1].cy;
  assign zero      = ~|st_q[SHW-1].data;

  // Next-state for every stage: shift forward on advance, otherwise hold.
  always_comb begin
    in_stage = '{valid: in_valid && advance, mode: aluc, amt: b, cy: 1'b0, data: a};
    if (advance) begin
      st_d[0] = step(in_stage, 0);
    end else begin
      st_d[0] = st_q[0];
    end
    for (int k = 1; k < SHW; k++) begin
      if (advance) begin
        st_d[k] = step(st_q[k-1], k);
      end else begin
        st_d[k] = st_q[k];
      end
    end
  end

  // Stage registers; reset flushes in-flight beats and clears c/carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: directed table, stalled stream, mid-flight reset,
// and an 8-bit build; a scoreboard checks ordering, values and latency.
`timescale 1ns/1ps
module tb_pipe_shifter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = 32'h0, c;
  logic [4:0]  b = 5'd0;
  logic [2:0]  aluc = 3'd0;
  logic        carry, zero;

  logic       iv8 = 1'b0, ir8, ov8, cy8, z8;
  logic [7:0] a8 = 8'h0, c8;
  logic [2:0] b8 = 3'd0, aluc8 = 3'd0;

  pipe_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready), .c(c), .carry(carry), .zero(zero));

  pipe_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .aluc(aluc8), .out_valid(ov8), .out_ready(1'b1), .c(c8), .carry(cy8), .zero(z8));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [4:0] b; logic [2:0] m; logic [31:0] c; logic cy; } vec_t;
  typedef struct { logic [31:0] c; logic cy; int acc; int stall0; } exp_t;

  vec_t        tbl [11];
  exp_t        sb [$];
  exp_t        e;
  int          checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
  bit          head_seen = 1'b0, was_stall = 1'b0;
  logic [31:0] prev_c, exp_c_drv;
  logic        prev_cy, exp_cy_drv;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial reference: one position per step.
  function automatic logic [32:0] model(input logic [31:0] av, input logic [4:0] bv, input logic [2:0] m);
    logic [31:0] x;
    logic        cy;
    x = av; cy = 1'b0;
    for (int i = 0; i < int'(bv); i++) begin
      case (m)
        3'b000:         begin cy = x[0];  x = {x[31], x[31:1]}; end
        3'b010:         begin cy = x[0];  x = {1'b0, x[31:1]};  end
        3'b001, 3'b011: begin cy = x[31]; x = {x[30:0], 1'b0};  end
        3'b100, 3'b110: begin cy = x[0];  x = {x[0], x[31:1]};  end
        default:        begin cy = x[31]; x = {x[30:0], x[31]}; end
      endcase
    end
    return {cy, x};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      head_seen = 1'b0;
      was_stall = 1'b0;
    end else begin
      if (was_stall)
        chk(out_valid && c == prev_c && carry == prev_cy, "stall_hold", {31'd0, out_valid, c}, {32'd1, prev_c});
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_out", {32'd0, c}, 64'd0);
        end else begin
          if (!head_seen) begin
            chk(cyc == sb[0].acc + 5 + stall_cnt - sb[0].stall0, "latency",
                64'(cyc - sb[0].acc), 64'(5 + stall_cnt - sb[0].stall0));
            head_seen = 1'b1;
          end
          if (out_ready) begin
            e = sb.pop_front();
            head_seen = 1'b0;
            chk(c == e.c, "result_c", {32'd0, c}, {32'd0, e.c});
            chk(carry == e.cy, "result_carry", {63'd0, carry}, {63'd0, e.cy});
            chk(zero == (e.c == 32'd0), "result_zero", {63'd0, zero}, {63'd0, e.c == 32'd0});
          end
        end
      end
      if (out_valid && !out_ready) begin
        chk(in_ready == 1'b0, "stall_in_ready", {63'd0, in_ready}, 64'd0);
        stall_cnt++;
        was_stall = 1'b1;
        prev_c = c;
        prev_cy = carry;
      end else begin
        was_stall = 1'b0;
      end
      if (in_valid && in_ready)
        sb.push_back('{c: exp_c_drv, cy: exp_cy_drv, acc: cyc, stall0: stall_cnt});
    end
  end

  task automatic send(input logic [31:0] av, input logic [4:0] bv, input logic [2:0] mv,
                      input logic [31:0] ec, input logic ecy);
    int n = 0;
    in_valid = 1'b1; a = av; b = bv; aluc = mv; exp_c_drv = ec; exp_cy_drv = ecy;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk(1'b0, "send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r;
    int          t0, n;
    tbl[0]  = '{32'h80000000, 5'd4,  3'b000, 32'hF8000000, 1'b0};
    tbl[1]  = '{32'h00000003, 5'd31, 3'b001, 32'h80000000, 1'b1};
    tbl[2]  = '{32'hF0000000, 5'd28, 3'b010, 32'h0000000F, 1'b0};
    tbl[3]  = '{32'h00000001, 5'd1,  3'b010, 32'h00000000, 1'b1};
    tbl[4]  = '{32'h00000001, 5'd1,  3'b100, 32'h80000000, 1'b1};
    tbl[5]  = '{32'h80000001, 5'd4,  3'b101, 32'h00000018, 1'b0};
    tbl[6]  = '{32'h80001234, 5'd0,  3'b000, 32'h80001234, 1'b0};
    tbl[7]  = '{32'hDEADBEEF, 5'd0,  3'b111, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{32'h12345678, 5'd4,  3'b011, 32'h23456780, 1'b1};
    tbl[9]  = '{32'h12345678, 5'd8,  3'b110, 32'h78123456, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 5'd31, 3'b000, 32'h00000000, 1'b1};

    // Reset with in_valid high: must be ignored.
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 5'd3;
    @(posedge clk); @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk(c == 32'd0, "rst_c", {32'd0, c}, 64'd0);
    chk(carry == 1'b0, "rst_carry", {63'd0, carry}, 64'd0);
    chk(zero == 1'b1, "rst_zero", {63'd0, zero}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0 && in_ready == 1'b1, "post_rst", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed table, back-to-back.
    for (int i = 0; i < 11; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].c, tbl[i].cy);
    drain();

    // 8-beat stream with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] x;
          logic [4:0]  bb;
          logic [2:0]  mm;
          x = $urandom; bb = 5'($urandom_range(0, 31)); mm = 3'($urandom_range(0, 7));
          r = model(x, bb, mm);
          send(x, bb, mm, r[31:0], r[32]);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      r = model(32'hA5A5A5A5 + i, 5'd1 + 5'(i), 3'b001);
      send(32'hA5A5A5A5 + i, 5'd1 + 5'(i), 3'b001, r[31:0], r[32]);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0 && in_ready == 1'b1, "midrst_flush", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(32'h0000F00F, 5'd8, 3'b101, 32'h00F00F00, 1'b0);
    drain();

    // 8-bit build: SRA 0x90 by 3.
    iv8 = 1'b1; a8 = 8'h90; b8 = 3'd3; aluc8 = 3'b000;
    @(negedge clk);
    chk(ir8 == 1'b1, "w8_in_ready", {63'd0, ir8}, 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov8 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(ov8 && (cyc - t0 == 3), "w8_latency", 64'(cyc - t0), 64'd3);
    chk(c8 == 8'hF2, "w8_c", {56'd0, c8}, 64'hF2);
    chk(cy8 == 1'b0 && z8 == 1'b0, "w8_carry_zero", {62'd0, cy8, z8}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
